// File: rtl/button_frame_decoder.sv
// button_frame_decoder
//   Consumes the UDP payload word stream of each received frame, picks out the
//   16-bit controller word at beat PAYLOAD_IDX, accepts it only when both bytes
//   agree, and drives the 8-bit button state. Repeated identical frames refresh
//   the link timer without re-pulsing buttons_valid. If no good frame arrives
//   within TIMEOUT_CYCLES, the buttons are cleared.
//
// Ports
//   clk           : single clock
//   rst           : synchronous reset, active low
//   axiiv/axiid   : payload word valid / data; one frame = one contiguous run
//   buttons       : current button state (registered)
//   buttons_valid : one-cycle pulse, coincident with a change of buttons
//   link_ok       : a good frame was seen within the timeout window
//   frame_count   : good frames accepted (saturating)
//   err_count     : rejected frames (saturating)
module button_frame_decoder #(
  parameter int DATA_SIZE      = 16,
  parameter int PAYLOAD_IDX    = 12,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiiv,
  input  logic [DATA_SIZE-1:0] axiid,
  output logic [7:0]           buttons,
  output logic                 buttons_valid,
  output logic                 link_ok,
  output logic [15:0]          frame_count,
  output logic [7:0]           err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    IDX        = 8'(PAYLOAD_IDX);

  typedef enum logic [1:0] {
    S_SKIP,
    S_IDLE,
    S_IN_FRAME
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             beat_q, beat_d;
  logic [DATA_SIZE-1:0]   cap_q, cap_d;
  logic                   got_q, got_d;
  logic [7:0]             buttons_q, buttons_d;
  logic                   bv_q, bv_d;
  logic                   link_q, link_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [15:0]            fc_q, fc_d;
  logic [7:0]             ec_q, ec_d;

  logic                   frame_end;
  logic                   frame_good;
  logic [7:0]             cur_beat;
  logic [TW-1:0]          timer_inc;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cap_d      = cap_q;
    got_d      = got_q;
    buttons_d  = buttons_q;
    bv_d       = 1'b0;
    link_d     = link_q;
    timer_d    = timer_q;
    fc_d       = fc_q;
    ec_d       = ec_q;
    frame_end  = 1'b0;
    frame_good = 1'b0;
    timer_inc  = timer_q + TW'(1);
    // The first beat of a frame is seen while still in IDLE, so it is beat 0.
    cur_beat   = (state_q == S_IN_FRAME) ? beat_q : 8'd0;

    case (state_q)
      S_SKIP: begin
        if (!axiiv) state_d = S_IDLE;
      end
      S_IDLE, S_IN_FRAME: begin
        if (axiiv) begin
          state_d = S_IN_FRAME;
          beat_d  = (cur_beat == 8'hFF) ? cur_beat : cur_beat + 8'd1;
          // got_q guard keeps capture single-shot once the counter saturates.
          if (!got_q && cur_beat == IDX) begin
            cap_d = axiid;
            got_d = 1'b1;
          end
        end else if (state_q == S_IN_FRAME) begin
          frame_end = 1'b1;
          state_d   = S_IDLE;
          beat_d    = 8'd0;
          cap_d     = '0;
          got_d     = 1'b0;
        end
      end
      default: state_d = S_SKIP;
    endcase

    frame_good = frame_end && got_q && (cap_q[15:8] == cap_q[7:0]);

    if (frame_good) begin
      // A good frame takes priority over a timeout expiring on the same edge.
      if (fc_q != 16'hFFFF) fc_d = fc_q + 16'd1;
      link_d    = 1'b1;
      timer_d   = '0;
      buttons_d = cap_q[7:0];
      bv_d      = (cap_q[7:0] != buttons_q);
    end else begin
      if (frame_end && ec_q != 8'hFF) ec_d = ec_q + 8'd1;
      if (link_q) begin
        timer_d = timer_inc;
        if (timer_inc == TIMER_LAST) begin
          link_d    = 1'b0;
          timer_d   = '0;
          buttons_d = 8'd0;
          bv_d      = (buttons_q != 8'd0);
        end
      end else begin
        timer_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_SKIP;
      beat_q    <= 8'd0;
      cap_q     <= '0;
      got_q     <= 1'b0;
      buttons_q <= 8'd0;
      bv_q      <= 1'b0;
      link_q    <= 1'b0;
      timer_q   <= '0;
      fc_q      <= 16'd0;
      ec_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cap_q     <= cap_d;
      got_q     <= got_d;
      buttons_q <= buttons_d;
      bv_q      <= bv_d;
      link_q    <= link_d;
      timer_q   <= timer_d;
      fc_q      <= fc_d;
      ec_q      <= ec_d;
    end
  end

  assign buttons       = buttons_q;
  assign buttons_valid = bv_q;
  assign link_ok       = link_q;
  assign frame_count   = fc_q;
  assign err_count     = ec_q;

endmodule

// File: tb/tb_button_frame_decoder.sv
module tb_button_frame_decoder;

  localparam int IDX = 12;
  localparam int TO  = 1000;

  logic        clk;
  logic        rst;
  logic        axiiv;
  logic [15:0] axiid;
  logic [7:0]  buttons;
  logic        buttons_valid;
  logic        link_ok;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  button_frame_decoder #(
    .DATA_SIZE(16),
    .PAYLOAD_IDX(IDX),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .buttons(buttons),
    .buttons_valid(buttons_valid),
    .link_ok(link_ok),
    .frame_count(frame_count),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mcheck   = 0;

  // Reference model: frame-level view (beats collected in a queue, timeout
  // expressed as distance in edges from the last accepted frame).
  logic [15:0] m_beats[$];
  bit          m_skip;
  bit          m_link;
  longint      m_edge;
  longint      m_last_good;
  logic [7:0]  m_buttons;
  logic        m_bv;
  logic [15:0] m_fc;
  logic [7:0]  m_ec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [15:0] d);
    logic [7:0]  prev;
    logic [15:0] w;
    bit          good;
    m_edge++;
    prev = m_buttons;
    good = 0;
    if (!r) begin
      m_skip = 1; m_beats.delete(); m_buttons = 8'd0; m_link = 0;
      m_fc = 16'd0; m_ec = 8'd0; m_bv = 1'b0;
    end else begin
      if (m_skip) begin
        if (!v) m_skip = 0;
      end else if (v) begin
        m_beats.push_back(d);
      end else if (m_beats.size() != 0) begin
        w = (m_beats.size() > IDX) ? m_beats[IDX] : 16'h0000;
        if (m_beats.size() > IDX && w[15:8] == w[7:0]) begin
          good = 1;
          if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
          m_buttons = w[7:0];
          m_link = 1;
          m_last_good = m_edge;
        end else if (m_ec != 8'hFF) begin
          m_ec = m_ec + 8'd1;
        end
        m_beats.delete();
      end
      if (!good && m_link && (m_edge - m_last_good == TO - 1)) begin
        m_link = 0;
        m_buttons = 8'd0;
      end
      m_bv = (m_buttons != prev);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] d);
    rst = r; axiiv = v; axiid = d;
    @(posedge clk);
    #1;
    model_edge(r, v, d);
    if (mcheck) begin
      chk("rnd_buttons", {24'd0, buttons}, {24'd0, m_buttons});
      chk("rnd_valid", {31'd0, buttons_valid}, {31'd0, m_bv});
      chk("rnd_link", {31'd0, link_ok}, {31'd0, m_link});
      chk("rnd_fcount", {16'd0, frame_count}, {16'd0, m_fc});
      chk("rnd_ecount", {24'd0, err_count}, {24'd0, m_ec});
    end
  endtask

  // Drives the beats of one frame; the caller issues the terminating idle beat.
  task automatic send_beats(input logic [15:0] word, input int len);
    for (int i = 0; i < len; i++) step(1'b1, 1'b1, (i == IDX) ? word : 16'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic random_phase();
    logic [7:0]  picks[4];
    logic [7:0]  b;
    logic [15:0] w;
    logic        r;
    int          len;
    int          gap;
    picks[0] = 8'h00; picks[1] = 8'h5A; picks[2] = 8'h5A; picks[3] = 8'hC3;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 20);
      b   = picks[$urandom_range(0, 3)];
      w   = ($urandom_range(0, 3) == 0) ? {b ^ 8'h10, b} : {b, b};
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
        step(r, 1'b1, (i == IDX) ? w : 16'($urandom));
      end
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(900, 1100) : $urandom_range(1, 4);
      idle(gap);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          len;
    logic [7:0]  eb;
    logic        ebv;
    logic [15:0] efc;
    logic [7:0]  eec;
  } vec_t;

  vec_t tbl[28];

  initial begin
    tbl[0] = '{16'hA5A5, 14, 8'hA5, 1'b1, 16'd1, 8'd0};
    for (int i = 1; i <= 20; i++) tbl[i] = '{16'hA5A5, 14, 8'hA5, 1'b0, 16'(1 + i), 8'd0};
    tbl[21] = '{16'hA55A, 14, 8'hA5, 1'b0, 16'd21, 8'd1};
    tbl[22] = '{16'hA5A5, 10, 8'hA5, 1'b0, 16'd21, 8'd2};
    tbl[23] = '{16'h3C3C, 13, 8'h3C, 1'b1, 16'd22, 8'd2};
    tbl[24] = '{16'h3C3C, 12, 8'h3C, 1'b0, 16'd22, 8'd3};
    tbl[25] = '{16'h0000, 14, 8'h00, 1'b1, 16'd23, 8'd3};
    tbl[26] = '{16'hFF00, 20, 8'h00, 1'b0, 16'd23, 8'd4};
    tbl[27] = '{16'h8181, 300, 8'h81, 1'b1, 16'd24, 8'd4};

    m_edge = 0; m_last_good = 0; m_skip = 1; m_link = 0;
    m_buttons = 0; m_bv = 0; m_fc = 0; m_ec = 0;
    rst = 1'b0; axiiv = 1'b0; axiid = 16'h0000;

    // Reset state
    step(1'b0, 1'b0, 16'h0); step(1'b0, 1'b0, 16'h0); step(1'b0, 1'b0, 16'h0);
    chk("rst_buttons", {24'd0, buttons}, 32'd0);
    chk("rst_valid", {31'd0, buttons_valid}, 32'd0);
    chk("rst_link", {31'd0, link_ok}, 32'd0);
    chk("rst_fcount", {16'd0, frame_count}, 32'd0);
    chk("rst_ecount", {24'd0, err_count}, 32'd0);
    idle(1);

    // Table-driven frames, 3-cycle gaps
    for (int i = 0; i < 28; i++) begin
      send_beats(tbl[i].word, tbl[i].len);
      idle(1);
      $display("frame %0d word=%h len=%0d -> buttons=%h valid=%b link=%b fc=%0d ec=%0d",
               i, tbl[i].word, tbl[i].len, buttons, buttons_valid, link_ok, frame_count, err_count);
      chk("tbl_buttons", {24'd0, buttons}, {24'd0, tbl[i].eb});
      chk("tbl_valid", {31'd0, buttons_valid}, {31'd0, tbl[i].ebv});
      chk("tbl_link", {31'd0, link_ok}, 32'd1);
      chk("tbl_fcount", {16'd0, frame_count}, {16'd0, tbl[i].efc});
      chk("tbl_ecount", {24'd0, err_count}, {24'd0, tbl[i].eec});
      idle(1);
      chk("tbl_valid_drop", {31'd0, buttons_valid}, 32'd0);
      idle(1);
    end

    // Timeout: clears on edge 999 after acceptance
    send_beats(16'h0101, 14); idle(1);
    chk("to1_accept", {24'd0, buttons}, 32'h01);
    chk("to1_pulse", {31'd0, buttons_valid}, 32'd1);
    for (int k = 1; k <= 999; k++) begin
      idle(1);
      if (k == 998) begin
        chk("to1_link_998", {31'd0, link_ok}, 32'd1);
        chk("to1_btn_998", {24'd0, buttons}, 32'h01);
      end
    end
    $display("timeout: link=%b buttons=%h valid=%b", link_ok, buttons, buttons_valid);
    chk("to1_link_999", {31'd0, link_ok}, 32'd0);
    chk("to1_btn_999", {24'd0, buttons}, 32'd0);
    chk("to1_pulse_999", {31'd0, buttons_valid}, 32'd1);
    idle(1);
    chk("to1_pulse_drop", {31'd0, buttons_valid}, 32'd0);

    // Good frame ending exactly on the expiry edge wins
    send_beats(16'h0101, 14); idle(1);
    chk("to2_pulse", {31'd0, buttons_valid}, 32'd1);
    idle(984);
    send_beats(16'h0101, 14); idle(1);
    $display("expiry-edge frame: link=%b buttons=%h valid=%b", link_ok, buttons, buttons_valid);
    chk("to2_link", {31'd0, link_ok}, 32'd1);
    chk("to2_buttons", {24'd0, buttons}, 32'h01);
    chk("to2_valid", {31'd0, buttons_valid}, 32'd0);
    idle(998);
    chk("to2_reload_998", {31'd0, link_ok}, 32'd1);
    idle(1);
    chk("to2_reload_999", {31'd0, link_ok}, 32'd0);

    // Expiry with buttons already zero: no pulse
    send_beats(16'h0000, 14); idle(1);
    chk("to3_link", {31'd0, link_ok}, 32'd1);
    chk("to3_valid", {31'd0, buttons_valid}, 32'd0);
    idle(999);
    chk("to3_link_off", {31'd0, link_ok}, 32'd0);
    chk("to3_no_pulse", {31'd0, buttons_valid}, 32'd0);
    chk("to3_fcount", {16'd0, frame_count}, 32'd28);
    chk("to3_ecount", {24'd0, err_count}, 32'd4);

    // Reset at beat 5..7 of a frame; the rest of it must be ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom));
    step(1'b0, 1'b1, 16'($urandom));
    chk("mid_rst_buttons", {24'd0, buttons}, 32'd0);
    chk("mid_rst_link", {31'd0, link_ok}, 32'd0);
    chk("mid_rst_fcount", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_ecount", {24'd0, err_count}, 32'd0);
    step(1'b0, 1'b1, 16'($urandom)); step(1'b0, 1'b1, 16'($urandom));
    for (int i = 8; i < 14; i++) step(1'b1, 1'b1, (i == IDX) ? 16'h3C3C : 16'($urandom));
    idle(1);
    chk("skip_fcount", {16'd0, frame_count}, 32'd0);
    chk("skip_ecount", {24'd0, err_count}, 32'd0);
    chk("skip_buttons", {24'd0, buttons}, 32'd0);
    idle(2);
    send_beats(16'h3C3C, 14); idle(1);
    $display("after reset: buttons=%h fc=%0d", buttons, frame_count);
    chk("post_rst_buttons", {24'd0, buttons}, 32'h3C);
    chk("post_rst_fcount", {16'd0, frame_count}, 32'd1);
    chk("post_rst_valid", {31'd0, buttons_valid}, 32'd1);

    // err_count saturation
    for (int i = 0; i < 255; i++) begin send_beats(16'h1111, 1); idle(1); end
    chk("ec_255", {24'd0, err_count}, 32'hFF);
    for (int i = 0; i < 45; i++) begin send_beats(16'h1111, 1); idle(1); end
    chk("ec_sat", {24'd0, err_count}, 32'hFF);
    chk("ec_sat_buttons", {24'd0, buttons}, 32'h3C);

    // frame_count saturation (preloaded near the top)
    @(negedge clk);
    force dut.fc_q = 16'hFFFD;
    #1;
    release dut.fc_q;
    send_beats(16'h3C3C, 14); idle(2);
    chk("fc_fffe", {16'd0, frame_count}, 32'hFFFE);
    send_beats(16'h3C3C, 14); idle(2);
    chk("fc_ffff", {16'd0, frame_count}, 32'hFFFF);
    send_beats(16'h3C3C, 14); idle(2);
    chk("fc_sat", {16'd0, frame_count}, 32'hFFFF);

    // Randomized traffic against the reference model
    step(1'b0, 1'b0, 16'h0); step(1'b0, 1'b0, 16'h0);
    mcheck = 1;
    idle(1);
    random_phase();
    mcheck = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_frame_decoder.md
# button_frame_decoder

Receive-side consumer of `network_stack_rx`: takes the UDP payload word stream (`axiov`/`axiod`) of each received frame, extracts the 16-bit controller word at a fixed beat index, validates that its two bytes match, and presents the 8-bit button state to the console-side logic. It suppresses duplicate updates from the sender's retransmissions and clears the buttons if no valid frame arrives within a timeout.

## Interface
Parameters:
- `DATA_SIZE`, 16: width of `axiid`; must be 16.
- `PAYLOAD_IDX`, 12: zero-based beat index within a frame that carries `{buttons,buttons}`.
- `TIMEOUT_CYCLES`, 5_000_000: cycles without a good frame before buttons clear (100 ms at 50 MHz).

Ports:
- `clk` in 1: the single clock (eth_refclk domain).
- `rst` in 1: synchronous, active-low reset.
- `axiiv` in 1: word valid from `network_stack_rx`; high for contiguous beats of one frame.
- `axiid` in 16: payload word.
- `buttons` out 8: current button state, registered.
- `buttons_valid` out 1: one-cycle pulse when `buttons` changes value.
- `link_ok` out 1: high while a good frame has been seen within `TIMEOUT_CYCLES`.
- `frame_count` out 16: good frames accepted, saturating at 16'hFFFF.
- `err_count` out 8: rejected frames, saturating at 8'hFF.

## Operation
- Frame = maximal run of consecutive cycles with `axiiv`=1. Frame end = first cycle with `axiiv`=0 after a high cycle.
- States:
  - SKIP: entered on reset; waits for `axiiv`=0, then goes to IDLE. This discards any frame in progress at reset release.
  - IDLE: `axiiv`=1 goes to IN_FRAME. The beat counter starts at 0 on this beat.
  - IN_FRAME: the beat counter increments on each valid beat and saturates at 255. When `beat==PAYLOAD_IDX`, latch `axiid` into `cap` and set `got`. On frame end, evaluate the frame and return to IDLE.
- Frame evaluation:
  - Good frame: `got`=1 and `cap[15:8]==cap[7:0]`.
  - Good frame actions: increment `frame_count` with saturation, set `link_ok`=1, reload the timeout counter to 0, and set `buttons<=cap[7:0]`.
  - Pulse `buttons_valid` only if `cap[7:0]!=buttons` (previous value).
  - Any other frame, whether too short or with mismatched bytes: increment `err_count` with saturation. Buttons, link and timer are unchanged.
  - `got` and `cap` clear on every return to IDLE.
- Timeout:
  - The counter increments every cycle while `link_ok`=1.
  - When it reaches `TIMEOUT_CYCLES-1`: set `link_ok`=0 and `buttons`=0. Pulse `buttons_valid` only if `buttons` was nonzero.
  - The counter holds at 0 while `link_ok`=0.
- Simultaneous frame end and timeout expiry: a good frame wins. The timer reloads, `link_ok` stays 1, and there is no clear.
- Duplicate frames (the sender retransmits up to 20×) produce no `buttons_valid` pulse but do count in `frame_count` and refresh the timer.

## Timing
- Reset values: `buttons`=0, `buttons_valid`=0, `link_ok`=0, `frame_count`=0, `err_count`=0, state=SKIP, timer=0.
- Latency: outputs update on the clock edge that samples the first `axiiv`=0 cycle after a frame. They are visible one cycle after the frame's last valid beat.
- `buttons_valid` is high for exactly one cycle, coincident with the new `buttons` value.
- No backpressure: every beat with `axiiv`=1 is consumed.
- Back-to-back frames need at least one `axiiv`=0 cycle between them. There is no other gap requirement.
- Frames longer than 256 beats are legal; the beat counter saturates and capture occurs once.
- Reset asserted mid-frame: all state clears at that edge and the partial frame is not counted. After reset release with `axiiv` still high, the remainder of that frame is ignored (SKIP).

## Test plan
- Reset, then one 14-beat frame with beat 12 = 16'hA5A5 → one cycle after the last beat: `buttons`=8'hA5, `buttons_valid` pulses once, `link_ok`=1, `frame_count`=1.
- Same frame repeated 20× with 3-cycle gaps → `buttons` stays 8'hA5, no further pulses, `frame_count`=21, `err_count`=0.
- Frame with beat 12 = 16'hA55A, then a 10-beat frame → `err_count`=2, `buttons` unchanged, no pulse.
- Good frame 16'h0101, then idle for `TIMEOUT_CYCLES` (set to 1000 in the bench) → at cycle 999 after acceptance: `link_ok`=0, `buttons`=0, one pulse. A good frame ending on the expiry cycle instead keeps `link_ok`=1 and `buttons`=8'h01.
- Reset pulled low at beat 5 of a frame and released at beat 8 → all outputs 0. The rest of that frame is ignored, and the next good frame 16'h3C3C yields `buttons`=8'h3C, `frame_count`=1.
- Force `frame_count` near saturation via 65 540 short good frames (or a bench `force`) → it holds at 16'hFFFF. Likewise `err_count` holds at 8'hFF after 300 bad frames.
